// File: rtl/display_scan_ctrl_if.sv
// Display scan controller bus.
//   master : the value source; drives en/data/blank_lz and observes the display lines
//   slave  : the scan controller; drives SEG/AN/dig/frame_done
//   en         scan enable (0 = display dark, scan restarts at digit 0)
//   data       16-bit value, nibble i -> digit i (digit 0 = rightmost)
//   blank_lz   suppress leading zeros
//   SEG        segments {g,f,e,d,c,b,a}, active-low
//   AN         digit anodes, active-low, at most one low
//   dig        index of the digit currently owning the segment bus
//   frame_done one-cycle pulse after the digit-3 drive period ends
interface display_scan_ctrl_if;
  logic        en;
  logic [15:0] data;
  logic        blank_lz;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic [1:0]  dig;
  logic        frame_done;

  modport master (
    output en, data, blank_lz,
    input  SEG, AN, dig, frame_done
  );

  modport slave (
    input  en, data, blank_lz,
    output SEG, AN, dig, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan scheduler for a 4-digit common-anode 7-segment display.
// One SEG bus is shared by four digits; each digit is driven for SCAN_DIV cycles,
// separated by BLANK_CYC dark cycles to avoid ghosting. The displayed value is
// snapshotted when digit 0 starts, so a frame never mixes two values.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  slave side of display_scan_ctrl_if (en/data/blank_lz in,
//        SEG/AN/dig/frame_done out, all outputs registered)
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.slave  bus
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       dig_q,   dig_d;
  logic [15:0]      snap_q,  snap_d;
  logic [3:0]       an_q,    an_d;
  logic [6:0]       seg_q,   seg_d;
  logic             fd_q,    fd_d;

  logic [3:0]       nib;
  logic             lz_hide;

  // Hex glyphs, active-low {g,f,e,d,c,b,a}: 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Next-state: blank/drive sequencing, digit rotation and frame snapshot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    snap_d  = snap_q;
    fd_d    = 1'b0;
    if (!bus.en) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      dig_d   = 2'd0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            // Snapshot only as digit 0 starts so a whole frame shows one value.
            if (dig_q == 2'd0) begin
              snap_d = bus.data;
            end
          end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == SCAN_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            dig_d   = dig_q + 2'd1;
            fd_d    = (dig_q == 2'd3);
          end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          dig_d   = 2'd0;
        end
      endcase
    end
  end

  // Leading-zero test: digit i>=1 hides when nibbles i..3 of the snapshot are zero.
  always_comb begin
    nib = snap_d[{dig_d, 2'b00} +: 4];
    case (dig_d)
      2'd1:    lz_hide = (snap_d[15:4]  == 12'h000);
      2'd2:    lz_hide = (snap_d[15:8]  == 8'h00);
      2'd3:    lz_hide = (snap_d[15:12] == 4'h0);
      default: lz_hide = 1'b0;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_d == ST_DRIVE) begin
      an_d  = ~(4'b0001 << dig_d);
      seg_d = (bus.blank_lz && lz_hide) ? SEG_OFF : hex_glyph(nib);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
      snap_q  <= 16'h0000;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.AN         = an_q;
  assign bus.dig        = dig_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (SCAN_DIV=4, BLANK_CYC=2).
// The reference model counts enabled edges since the last restart and derives
// the digit, blank/lit phase, frame pulse and snapshot from frame arithmetic.
module tb_display_scan_ctrl;

  localparam int unsigned SD    = 4;
  localparam int unsigned BC    = 2;
  localparam int unsigned P     = SD + BC;
  localparam int unsigned FRAME = 4 * P;

  logic clk = 1'b0;
  logic rst;

  display_scan_ctrl_if bus_if ();

  display_scan_ctrl #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       fd;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model state
  int          k = 0;
  logic [15:0] m_snap = 16'h0000;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
      4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
      4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
      4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic bit model_lit(input int kk, output int d);
    int f;
    f = kk % FRAME;
    d = f / P;
    return (kk > 0) && ((f % P) >= BC);
  endfunction

  function automatic exp_t model_out(input logic lz);
    exp_t e;
    int   f, d;
    logic [15:0] upper;
    e.an = 4'hF; e.seg = 7'h7F; e.dig = 2'd0; e.fd = 1'b0;
    if (k > 0) begin
      f     = k % FRAME;
      d     = f / P;
      e.dig = 2'(d);
      e.fd  = (f == 0);
      if ((f % P) >= BC) begin
        e.an  = ~(4'(1) << d);
        upper = m_snap >> (4 * d);
        if (lz && d >= 1 && upper == 16'h0000) e.seg = 7'h7F;
        else e.seg = glyph(upper[3:0]);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t, k=%0d)", name, act, exp, $time, k);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge and queue the expectation.
  // With async_rst set, reset is asserted between edges and reset values are expected immediately.
  task automatic step(input bit async_rst = 1'b0);
    logic        e_rst, e_en, e_lz;
    logic [15:0] e_data;
    @(posedge clk);
    e_rst = rst; e_en = bus_if.en; e_lz = bus_if.blank_lz; e_data = bus_if.data;
    #1;
    if (!e_rst) begin
      k = 0; m_snap = 16'h0000;
    end else if (!e_en) begin
      k = 0;
    end else begin
      k++;
      if ((k % FRAME) == BC) m_snap = e_data;
    end
    if (async_rst) begin
      rst = 1'b0;
      k = 0; m_snap = 16'h0000;
    end
    sb_q.push_back(model_out(bus_if.blank_lz));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model shows digit `want` lit (bounded).
  task automatic run_until_lit(input int want, input string name);
    int d;
    int guard;
    guard = 0;
    while (!(model_lit(k, d) && d == want && ((k % FRAME) % P) < P - 1)) begin
      step();
      guard++;
      if (guard > 200) begin
        n_cmp++; n_err++;
        $display("FAIL %s: digit %0d never lit within 200 cycles", name, want);
        return;
      end
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation on every falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("AN",         16'(bus_if.AN),         16'(e.an));
      chk("SEG",        16'(bus_if.SEG),        16'(e.seg));
      chk("dig",        16'(bus_if.dig),        16'(e.dig));
      chk("frame_done", 16'(bus_if.frame_done), 16'(e.fd));
    end
  end

  initial begin
    logic [15:0] mask;
    int          sel;
    rst = 1'b0;
    bus_if.en = 1'b0; bus_if.data = 16'h0000; bus_if.blank_lz = 1'b0;
    run(2);
    rst = 1'b1;

    // Basic scan of 1234, several frames
    bus_if.en = 1'b1; bus_if.data = 16'h1234;
    run(2 * FRAME + 3);

    // Data change while digit 1 lit must not tear the current frame
    run_until_lit(1, "wait_dig1");
    bus_if.data = 16'hABCD;
    run(2 * FRAME);

    // Leading-zero suppression
    bus_if.blank_lz = 1'b1; bus_if.data = 16'h0040;
    run(2 * FRAME);
    bus_if.data = 16'h0000;
    run(2 * FRAME);
    bus_if.data = 16'h0105;
    run(2 * FRAME);
    bus_if.blank_lz = 1'b0;
    run(FRAME);

    // Enable drop while digit 2 lit, then re-enable
    run_until_lit(2, "wait_dig2");
    bus_if.en = 1'b0;
    run(3);
    bus_if.en = 1'b1;
    run(FRAME + 5);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus_if.en = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 3);
        mask = (sel == 0) ? 16'h000F : (sel == 1) ? 16'h00FF :
               (sel == 2) ? 16'h0FFF : 16'hFFFF;
        bus_if.data = 16'($urandom) & mask;
      end
      if ($urandom_range(0, 15) == 0) bus_if.blank_lz = ~bus_if.blank_lz;
      step();
    end

    // Asynchronous reset in the middle of a drive period
    bus_if.en = 1'b1; bus_if.data = 16'h5A3C;
    run_until_lit(0, "wait_dig0");
    step(1'b1);
    run(2);
    rst = 1'b1;
    run(FRAME + 4);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 16'(sb_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
